// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-back arbiter.
// Covers the datapath sizes, the requester indices and the pointer advance.
package regfile_wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REGW = 5;

  localparam logic [1:0] REQ_PIPE = 2'd0;
  localparam logic [1:0] REQ_CSR  = 2'd1;
  localparam logic [1:0] REQ_MDU  = 2'd2;
  localparam int         NUM_WB_REQ = 3;

  // Priority moves to the requester just after the winner, modulo three.
  function automatic logic [1:0] next_ptr(input logic [1:0] gnt_idx);
    case (gnt_idx)
      2'd0:    next_ptr = 2'd1;
      2'd1:    next_ptr = 2'd2;
      default: next_ptr = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter3.sv
// Combinational three-way round-robin picker.
// The priority pointer is owned by the parent; this block only searches from it.
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [3:0] req_x_s;
  logic [1:0] o0_s, o1_s, o2_s;

  assign req_x_s = {1'b0, req};

  // Search order ptr, ptr+1, ptr+2; an out-of-range pointer behaves like 0.
  always_comb begin
    o0_s = 2'd0;
    o1_s = 2'd1;
    o2_s = 2'd2;
    case (ptr)
      2'd1: begin
        o0_s = 2'd1;
        o1_s = 2'd2;
        o2_s = 2'd0;
      end
      2'd2: begin
        o0_s = 2'd2;
        o1_s = 2'd0;
        o2_s = 2'd1;
      end
      default: begin
        o0_s = 2'd0;
        o1_s = 2'd1;
        o2_s = 2'd2;
      end
    endcase

    if (req_x_s[o0_s]) begin
      gnt_idx = o0_s;
    end else if (req_x_s[o1_s]) begin
      gnt_idx = o1_s;
    end else if (req_x_s[o2_s]) begin
      gnt_idx = o2_s;
    end else begin
      gnt_idx = o0_s;
    end

    if (|req) begin
      gnt = 3'b001 << gnt_idx;
    end else begin
      gnt = 3'b000;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port among pipe, CSR and MDU,
// with a registered write stage and a scoreboard of MDU-owned destinations.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_valid,
  input  logic [REGW-1:0] pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_ready,
  input  logic            csr_valid,
  input  logic [REGW-1:0] csr_rd,
  input  logic [XLEN-1:0] csr_data,
  output logic            csr_ready,
  input  logic            mdu_valid,
  input  logic [REGW-1:0] mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  input  logic            mdu_issue,
  input  logic [REGW-1:0] mdu_issue_rd,
  output logic            rf_we,
  output logic [REGW-1:0] rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy
);
  import regfile_wb_arbiter_pkg::*;

  logic [NUM_WB_REQ-1:0] req_s, gnt_s;
  logic [1:0]            gnt_idx_s;
  logic [REGW-1:0]       sel_rd_s;
  logic [XLEN-1:0]       sel_data_s;

  logic [1:0]      ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [REGW-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign req_s = {mdu_valid, csr_valid, pipe_valid};

  rr_arbiter3 u_rr_arbiter3 (
    .req     (req_s),
    .ptr     (ptr_q),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign pipe_ready = gnt_s[REQ_PIPE];
  assign csr_ready  = gnt_s[REQ_CSR];
  assign mdu_ready  = gnt_s[REQ_MDU];

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

  // Route the winning request's destination and data.
  always_comb begin
    case (gnt_idx_s)
      REQ_CSR: begin
        sel_rd_s   = csr_rd;
        sel_data_s = csr_data;
      end
      REQ_MDU: begin
        sel_rd_s   = mdu_rd;
        sel_data_s = mdu_data;
      end
      default: begin
        sel_rd_s   = pipe_rd;
        sel_data_s = pipe_data;
      end
    endcase
  end

  // Next pointer and write stage; writes to x0 are accepted but dropped.
  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (|gnt_s) begin
      ptr_d = next_ptr(gnt_idx_s);
      if (sel_rd_s != {REGW{1'b0}}) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = sel_rd_s;
        rf_wdata_d = sel_data_s;
      end else begin
        rf_we_d = 1'b0;
      end
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // Scoreboard: clear on MDU accept first so a same-edge issue re-sets the bit.
  always_comb begin
    busy_d = busy_q;
    if (gnt_s[REQ_MDU]) begin
      busy_d[mdu_rd] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (mdu_issue && (mdu_issue_rd != {REGW{1'b0}})) begin
      busy_d[mdu_issue_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 2'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= {REGW{1'b0}};
      rf_wdata_q <= {XLEN{1'b0}};
      busy_q     <= {NREG{1'b0}};
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single write port among three write-back requesters: the main pipeline, the CSR unit, and the multi-cycle multiply/divide unit (MDU).
- Uses valid/ready handshakes and rotating round-robin priority.
- Registers the winning write for one cycle before it reaches the register file.
- Keeps a pending-write scoreboard of destination registers owned by in-flight MDU operations, so that hazard logic can stall dependent instructions.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers
- REGW, 5, register index width (log2 NREG)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_valid / pipe_rd / pipe_data  in  1 / REGW / XLEN  pipeline write request
- pipe_ready  out  1  pipeline request accepted this cycle
- csr_valid / csr_rd / csr_data  in  1 / REGW / XLEN  CSR read-result write request
- csr_ready  out  1  CSR request accepted this cycle
- mdu_valid / mdu_rd / mdu_data  in  1 / REGW / XLEN  MDU completion write request
- mdu_ready  out  1  MDU request accepted this cycle
- mdu_issue  in  1  an MDU operation starts this cycle
- mdu_issue_rd  in  REGW  destination of the issuing MDU operation
- rf_we / rf_rd / rf_wdata  out  1 / REGW / XLEN  registered write to the register file
- busy  out  NREG  scoreboard; bit i is high while register i awaits an MDU write

## Operation
Requester indices: 0 = pipe, 1 = csr, 2 = mdu.

Handshake:
- A request is accepted in a cycle where valid and ready are both high.
- Once valid is raised, it must stay high, with rd and data stable, until accepted.
- ready is combinational from the current valid inputs and the priority pointer.
- Exactly one ready goes high per cycle when any valid is high.

Arbitration:
- Rotating priority. The 2-bit pointer ptr (values 0..2) names the highest-priority requester.
- Search order: ptr, ptr+1, ptr+2, each mod 3.
- After a grant to requester g, ptr becomes (g+1) mod 3.
- ptr is unchanged in cycles with no grant.

Write register:
- On a grant with rd != 0: rf_we is set to 1, and rf_rd/rf_wdata load the granted request's rd/data.
- On a grant with rd == 0: the request is accepted and discarded; rf_we is set to 0.
- With no grant: rf_we is set to 0; rf_rd and rf_wdata hold their values.

Scoreboard busy[NREG-1:0]:
- mdu_issue with mdu_issue_rd != 0 sets busy[mdu_issue_rd].
- An accepted MDU request clears busy[mdu_rd].
- Same register set and cleared on the same edge: the set wins (a back-to-back MDU op reuses rd).
- busy[0] is always 0.
- mdu_issue while busy[mdu_issue_rd] is already 1 leaves the bit at 1.

Reset, asynchronous:
- ptr = 0, rf_we = 0, rf_rd = 0, rf_wdata = 0, busy = 0.
- Any request in flight is discarded. Requesters must re-present it after reset.

## Timing
- Accept at edge N -> rf_we/rf_rd/rf_wdata valid from N until edge N+1. The write lands in the register file at edge N+1.
- Latency from valid (with ready high) to the register file being written: 1 registered stage.
- busy set by mdu_issue at edge N is visible from N onward.
- busy cleared by MDU accept at edge N drops at N. This is the same cycle rf_we presents the data, so the register file's same-cycle bypass covers any dependent read.
- Worst-case wait for a continuously valid requester: 2 cycles (3 requesters, round-robin).
- Throughput: one accepted write per cycle.

## Structure
- Shared package holds:
  - XLEN, NREG, REGW constants
  - REQ_PIPE=0, REQ_CSR=1, REQ_MDU=2 index constants
  - NUM_WB_REQ=3
- Sub-module rr_arbiter3:
  - Inputs: req[2:0], ptr.
  - Outputs: one-hot gnt[2:0], encoded gnt_idx.
  - Purely combinational. ptr is stored in the parent.
- Parent holds ptr, the write register, the scoreboard, and the ready/data muxing.

## Test plan
- Reset mid-stream:
  - Stimulus: assert rst while pipe_valid=1 and busy[5]=1.
  - Response: outputs clear immediately with no clock edge; busy=0; ptr=0; after release, first grant goes to pipe.
- All three requesters valid for 6 cycles, with rd=1,2,3 and data=A,B,C:
  - Grant order pipe, csr, mdu, pipe, csr, mdu.
  - rf_rd sequence 1,2,3,1,2,3, each one cycle after its accept.
- pipe_valid with rd=0, data=DEAD:
  - Response: pipe_ready=1; next cycle rf_we=0; ptr advances to 1.
- MDU scoreboard lifecycle:
  - Stimulus: mdu_issue with rd=7, then 4 idle cycles, then mdu_valid with rd=7, data=12345678.
  - Response: busy[7]=1 from the issue edge; cleared at the accept edge; rf_we=1, rf_rd=7, rf_wdata=12345678 in the following cycle.
- Simultaneous set and clear:
  - Stimulus: MDU accept of rd=9 on the same edge as mdu_issue with rd=9.
  - Response: busy[9] stays 1.
- Backpressure with csr and mdu held valid:
  - Stimulus: ptr=1; csr_valid and mdu_valid both held high.
  - Response: csr granted first; mdu_ready=1 on the next cycle; mdu_rd/mdu_data are unchanged while waiting; the data is written exactly once.
